lc3b_mem_bridge: RTL and testbench
==================================

Name: lc3b_mem_bridge

Overview:
Sits directly downstream of the LC-3b control/datapath memory port. It converts the CPU's level-held mem_read/mem_write request into a registered, word-aligned request to physical memory. It then returns a single-cycle mem_resp with read data captured from memory. All CPU-side and memory-side outputs are registered.

Parameters:
TIMEOUT_CYCLES, 255, number of ACCESS cycles to wait for pmem_resp before aborting (used only with MEM_TIMEOUT_EN).
ADDR_W, 16, address width.
DATA_W, 16, data width.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
mem_read  input  1  CPU read request, held until mem_resp
mem_write  input  1  CPU write request, held until mem_resp
mem_address  input  ADDR_W  CPU byte address
mem_wdata  input  DATA_W  CPU write data
mem_byte_enable  input  2  CPU write byte mask (lc3b_mem_wmask)
mem_rdata  output  DATA_W  read data, valid in the mem_resp cycle
mem_resp  output  1  one-cycle completion pulse
mem_err  output  1  one-cycle abort pulse, coincident with mem_resp
pmem_read  output  1  physical read strobe, held until pmem_resp
pmem_write  output  1  physical write strobe, held until pmem_resp
pmem_addr  output  ADDR_W  word-aligned address, bit 0 forced to 0
pmem_wdata  output  DATA_W  latched write data
pmem_wmask  output  2  latched byte mask
pmem_rdata  input  DATA_W  physical read data, valid with pmem_resp
pmem_resp  input  1  physical completion, single cycle

Behaviour:
- State machine: IDLE, ACCESS, RESPOND.
- Reset (rst_n=0 at the edge): state goes to IDLE. mem_resp, mem_err, pmem_read and pmem_write go to 0. mem_rdata, pmem_addr, pmem_wdata go to 0. pmem_wmask goes to 2'b00. This applies in any state. An in-flight transaction is dropped, and no mem_resp is issued for it.
- IDLE:
  - If mem_write=1, latch address (bit 0 cleared), wdata and byte_enable. Next edge: pmem_write=1, go to ACCESS.
  - Else if mem_read=1, latch address. Next edge: pmem_read=1, go to ACCESS.
  - If both are asserted, the write wins. No error is flagged.
  - pmem_resp arriving in IDLE is ignored.
- ACCESS:
  - Strobe and latched fields are held constant. CPU-side inputs are not re-sampled.
  - On pmem_resp=1: clear the strobe. For a read, capture pmem_rdata into mem_rdata. Set mem_resp=1 and go to RESPOND.
- RESPOND:
  - mem_resp (and mem_err if set) are high for exactly this one cycle. They are cleared on the next edge, and the state returns to IDLE.
  - The request level in this cycle is not treated as a new request. A request still high in the following IDLE cycle starts a new transaction.
- Latency: request first seen at edge N; strobe visible after N; pmem_resp at edge M; mem_resp visible after M. The minimum request-to-response time is 3 cycles, and throughput is 1 transaction per 3 cycles at best.
- mem_rdata holds its last captured value until the next read completes. Writes do not modify it.
- mem_err is 0 on every normal completion.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8+ bit counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES without pmem_resp, the strobe drops, mem_rdata is set to 16'hDEAD, and mem_resp=1 with mem_err=1 for one cycle. The state then goes through RESPOND to IDLE.
  - If pmem_resp arrives in the same cycle the count hits the limit, it is treated as normal completion with mem_err=0.
- Not defined: no counter; ACCESS waits indefinitely; mem_err is tied to 0.

Test Plan:
- Read: mem_read=1, addr 16'h3001; pmem_resp after 2 cycles with rdata 16'hBEEF -> pmem_addr=16'h3000, pmem_read high 3 cycles; mem_resp high exactly 1 cycle with mem_rdata=16'hBEEF; pmem_read=0 afterward.
- Write: mem_write=1, addr 16'h0042, wdata 16'h1234, byte_enable 2'b01; pmem_resp after 1 cycle -> pmem_write=1, pmem_wdata=16'h1234, pmem_wmask=2'b01; mem_resp one pulse; mem_rdata unchanged.
- Simultaneous request: mem_read=mem_write=1 -> pmem_write=1 and pmem_read=0 throughout.
- Back-to-back: mem_read held across RESPOND and the next cycle -> exactly two pmem_read transactions, 1 idle cycle between them, no extra mem_resp.
- Reset mid-ACCESS: rst_n=0 for 1 cycle while pmem_read=1, then pmem_resp=1 -> strobe 0 after the reset edge; no mem_resp; state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no pmem_resp -> after 4 ACCESS cycles mem_resp=mem_err=1 for one cycle, mem_rdata=16'hDEAD, pmem_read=0.

Source files
------------

// File: rtl/lc3b_mem_bridge.sv
// ============================================================================
// lc3b_mem_bridge
// ----------------------------------------------------------------------------
// Purpose:
//   Bridges the LC-3b CPU memory port to a physical memory. The CPU holds
//   mem_read/mem_write at a steady level until it sees mem_resp. This block
//   turns that level into one registered, word-aligned physical request. It
//   then returns a single-cycle mem_resp, together with read data captured
//   from memory. Every output is registered.
//
//   The transaction sequence is IDLE -> ACCESS -> RESPOND -> IDLE. As a
//   result, at most one transaction completes every three cycles.
//
// Configuration macro:
//   MEM_TIMEOUT_EN - when defined, an ACCESS that gets no pmem_resp within
//                    TIMEOUT_CYCLES cycles is aborted. The abort returns
//                    mem_rdata = 16'hDEAD and pulses mem_err together with
//                    mem_resp. When the macro is undefined, ACCESS waits
//                    forever and mem_err is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES - ACCESS cycles allowed before an abort (timeout build only)
//   ADDR_W         - address width
//   DATA_W         - data width
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   synchronous active-low reset
//   mem_read        in   CPU read request, held until mem_resp
//   mem_write       in   CPU write request, held until mem_resp
//   mem_address     in   CPU byte address
//   mem_wdata       in   CPU write data
//   mem_byte_enable in   CPU write byte mask
//   mem_rdata       out  read data, valid in the mem_resp cycle
//   mem_resp        out  one-cycle completion pulse
//   mem_err         out  one-cycle abort pulse, coincident with mem_resp
//   pmem_read       out  physical read strobe, held until pmem_resp
//   pmem_write      out  physical write strobe, held until pmem_resp
//   pmem_addr       out  word-aligned physical address (bit 0 cleared)
//   pmem_wdata      out  latched write data
//   pmem_wmask      out  latched byte mask
//   pmem_rdata      in   physical read data, valid with pmem_resp
//   pmem_resp       in   physical completion, single cycle
// ============================================================================
module lc3b_mem_bridge #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [1:0]        mem_byte_enable,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_resp,
   output logic              mem_err,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [DATA_W-1:0] pmem_wdata,
   output logic [1:0]        pmem_wmask,
   input  logic [DATA_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESPOND
   } state_t;

   state_t state;

   // Masking with an all-ones-but-bit-0 constant keeps every address bit
   // in use and forces word alignment.
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);

`ifdef MEM_TIMEOUT_EN
   localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt;
`else
   // With no abort path, no error can ever be reported.
   assign mem_err = 1'b0;
`endif

   // Transaction sequencer with registered outputs.
   //
   // IDLE samples the CPU request. A write wins over a simultaneous read.
   // The request fields are latched here, and the strobe is raised.
   //
   // ACCESS holds the strobe and the latched fields until pmem_resp
   // arrives. During ACCESS the CPU inputs are deliberately not looked at.
   // pmem_read stays high until completion, so it also identifies the
   // transaction as a read when deciding whether to capture data.
   //
   // RESPOND is the single cycle in which mem_resp is visible. The request
   // level seen during RESPOND is ignored: the CPU has not yet had a chance
   // to drop it. A request that is still present in the following IDLE
   // cycle is treated as a new transaction.
   //
   // In the timeout build, a counter tracks the number of ACCESS cycles.
   // A response that arrives in the same cycle as the limit takes priority
   // and completes normally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         mem_resp   <= 1'b0;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
         mem_rdata  <= '0;
         pmem_addr  <= '0;
         pmem_wdata <= '0;
         pmem_wmask <= 2'b00;
`ifdef MEM_TIMEOUT_EN
         mem_err    <= 1'b0;
         tmo_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (mem_write) begin
                  pmem_addr  <= mem_address & WORD_MASK;
                  pmem_wdata <= mem_wdata;
                  pmem_wmask <= mem_byte_enable;
                  pmem_write <= 1'b1;
                  state      <= ACCESS;
`ifdef MEM_TIMEOUT_EN
                  tmo_cnt    <= '0;
`endif
               end else if (mem_read) begin
                  pmem_addr  <= mem_address & WORD_MASK;
                  pmem_read  <= 1'b1;
                  state      <= ACCESS;
`ifdef MEM_TIMEOUT_EN
                  tmo_cnt    <= '0;
`endif
               end
            end

            ACCESS: begin
               if (pmem_resp) begin
                  if (pmem_read) begin
                     mem_rdata <= pmem_rdata;
                  end
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
                  mem_resp   <= 1'b1;
                  state      <= RESPOND;
               end
`ifdef MEM_TIMEOUT_EN
               else if (tmo_cnt == TMO_LIMIT) begin
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
                  mem_rdata  <= DATA_W'(16'hDEAD);
                  mem_resp   <= 1'b1;
                  mem_err    <= 1'b1;
                  state      <= RESPOND;
               end else begin
                  tmo_cnt    <= tmo_cnt + 1'b1;
               end
`endif
            end

            RESPOND: begin
               mem_resp <= 1'b0;
`ifdef MEM_TIMEOUT_EN
               mem_err  <= 1'b0;
`endif
               state    <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lc3b_mem_bridge.sv
// ============================================================================
// tb_lc3b_mem_bridge
// ----------------------------------------------------------------------------
// Directed testbench for lc3b_mem_bridge. Each scenario task drives its own
// stimulus, acts as the physical memory, and compares the DUT outputs with
// hand-computed values. Inputs change, and outputs are sampled, on the
// falling edge of clk, away from the active rising edge.
// The abort scenario is built only when MEM_TIMEOUT_EN is defined.
// ============================================================================
module tb_lc3b_mem_bridge;

   logic        clk;
   logic        rst_n;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_rdata;
   logic        mem_resp;
   logic        mem_err;
   logic        pmem_read;
   logic        pmem_write;
   logic [15:0] pmem_addr;
   logic [15:0] pmem_wdata;
   logic [1:0]  pmem_wmask;
   logic [15:0] pmem_rdata;
   logic        pmem_resp;

   int checks;
   int failures;

   lc3b_mem_bridge #(
      .TIMEOUT_CYCLES (4),
      .ADDR_W         (16),
      .DATA_W         (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .mem_err         (mem_err),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_addr       (pmem_addr),
      .pmem_wdata      (pmem_wdata),
      .pmem_wmask      (pmem_wmask),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reset the bridge and confirm that every registered output is cleared.
   task automatic test_reset();
      rst_n           = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = 16'h0000;
      mem_wdata       = 16'h0000;
      mem_byte_enable = 2'b00;
      pmem_rdata      = 16'h0000;
      pmem_resp       = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (mem_resp !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mem_resp got %b expected 0", mem_resp);
      end
      checks++;
      if (mem_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mem_err got %b expected 0", mem_err);
      end
      checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_strobes got r=%b w=%b expected 0 0", pmem_read, pmem_write);
      end
      checks++;
      if (pmem_addr !== 16'h0000 || pmem_wdata !== 16'h0000 || pmem_wmask !== 2'b00) begin
         failures++;
         $display("[TB] FAIL reset_fields got addr=%h wdata=%h wmask=%b expected 0000 0000 00",
                  pmem_addr, pmem_wdata, pmem_wmask);
      end
      checks++;
      if (mem_rdata !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL reset_mem_rdata got %h expected 0000", mem_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Read from 0x3001. Memory answers in the third ACCESS cycle with 0xBEEF.
   task automatic test_read();
      mem_read    = 1'b1;
      mem_address = 16'h3001;
      @(negedge clk);
      checks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr !== 16'h3000) begin
         failures++;
         $display("[TB] FAIL read_issue got r=%b w=%b addr=%h expected 1 0 3000",
                  pmem_read, pmem_write, pmem_addr);
      end
      checks++;
      if (mem_resp !== 1'b0) begin
         failures++;
         $display("[TB] FAIL read_early_resp got %b expected 0", mem_resp);
      end
      @(negedge clk);
      checks++;
      if (pmem_read !== 1'b1) begin
         failures++;
         $display("[TB] FAIL read_hold2 got %b expected 1", pmem_read);
      end
      @(negedge clk);
      checks++;
      if (pmem_read !== 1'b1 || pmem_addr !== 16'h3000) begin
         failures++;
         $display("[TB] FAIL read_hold3 got r=%b addr=%h expected 1 3000", pmem_read, pmem_addr);
      end
      pmem_resp  = 1'b1;
      pmem_rdata = 16'hBEEF;
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = 16'h0000;
      checks++;
      if (mem_resp !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 16'hBEEF) begin
         failures++;
         $display("[TB] FAIL read_respond got resp=%b err=%b rdata=%h expected 1 0 beef",
                  mem_resp, mem_err, mem_rdata);
      end
      checks++;
      if (pmem_read !== 1'b0) begin
         failures++;
         $display("[TB] FAIL read_strobe_drop got %b expected 0", pmem_read);
      end
      mem_read = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || mem_rdata !== 16'hBEEF) begin
         failures++;
         $display("[TB] FAIL read_after got resp=%b r=%b rdata=%h expected 0 0 beef",
                  mem_resp, pmem_read, mem_rdata);
      end
   endtask

   // Write 0x1234 to 0x0042 with mask 01. The CPU-side inputs are changed
   // during ACCESS to show that the latched values are held.
   task automatic test_write();
      mem_write       = 1'b1;
      mem_address     = 16'h0042;
      mem_wdata       = 16'h1234;
      mem_byte_enable = 2'b01;
      @(negedge clk);
      checks++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 16'h0042 ||
          pmem_wdata !== 16'h1234 || pmem_wmask !== 2'b01) begin
         failures++;
         $display("[TB] FAIL write_issue got w=%b r=%b addr=%h wdata=%h wmask=%b expected 1 0 0042 1234 01",
                  pmem_write, pmem_read, pmem_addr, pmem_wdata, pmem_wmask);
      end
      mem_address     = 16'h1111;
      mem_wdata       = 16'hFFFF;
      mem_byte_enable = 2'b10;
      @(negedge clk);
      checks++;
      if (pmem_write !== 1'b1 || pmem_addr !== 16'h0042 || pmem_wdata !== 16'h1234 ||
          pmem_wmask !== 2'b01) begin
         failures++;
         $display("[TB] FAIL write_hold got w=%b addr=%h wdata=%h wmask=%b expected 1 0042 1234 01",
                  pmem_write, pmem_addr, pmem_wdata, pmem_wmask);
      end
      pmem_resp  = 1'b1;
      pmem_rdata = 16'h5555;
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = 16'h0000;
      checks++;
      if (mem_resp !== 1'b1 || mem_err !== 1'b0 || pmem_write !== 1'b0) begin
         failures++;
         $display("[TB] FAIL write_respond got resp=%b err=%b w=%b expected 1 0 0",
                  mem_resp, mem_err, pmem_write);
      end
      checks++;
      if (mem_rdata !== 16'hBEEF) begin
         failures++;
         $display("[TB] FAIL write_rdata_kept got %h expected beef", mem_rdata);
      end
      mem_write = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b0 || pmem_write !== 1'b0) begin
         failures++;
         $display("[TB] FAIL write_after got resp=%b w=%b expected 0 0", mem_resp, pmem_write);
      end
   endtask

   // Read and write requested together: the write wins, and no read strobe
   // is ever raised.
   task automatic test_simultaneous();
      mem_read        = 1'b1;
      mem_write       = 1'b1;
      mem_address     = 16'h2003;
      mem_wdata       = 16'h5A5A;
      mem_byte_enable = 2'b11;
      @(negedge clk);
      checks++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 16'h2002 ||
          pmem_wdata !== 16'h5A5A || pmem_wmask !== 2'b11) begin
         failures++;
         $display("[TB] FAIL simul_issue got w=%b r=%b addr=%h wdata=%h wmask=%b expected 1 0 2002 5a5a 11",
                  pmem_write, pmem_read, pmem_addr, pmem_wdata, pmem_wmask);
      end
      pmem_resp  = 1'b1;
      pmem_rdata = 16'h7777;
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = 16'h0000;
      checks++;
      if (mem_resp !== 1'b1 || mem_err !== 1'b0 || pmem_read !== 1'b0 || mem_rdata !== 16'hBEEF) begin
         failures++;
         $display("[TB] FAIL simul_respond got resp=%b err=%b r=%b rdata=%h expected 1 0 0 beef",
                  mem_resp, mem_err, pmem_read, mem_rdata);
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0) begin
         failures++;
         $display("[TB] FAIL simul_after got r=%b w=%b resp=%b expected 0 0 0",
                  pmem_read, pmem_write, mem_resp);
      end
   endtask

   // The read request is held across RESPOND and into the next IDLE cycle.
   // Memory answers in the first ACCESS cycle. Expect exactly two read
   // transactions, with one IDLE cycle between the first response and the
   // second strobe, and exactly two responses.
   task automatic test_back_to_back();
      int strobe_rises;
      int resp_pulses;
      int first_resp_cyc;
      int second_rise_cyc;
      logic prev_read;
      strobe_rises    = 0;
      resp_pulses     = 0;
      first_resp_cyc  = -1;
      second_rise_cyc = -1;
      prev_read       = 1'b0;
      mem_read        = 1'b1;
      mem_address     = 16'h0100;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (pmem_read && !prev_read) begin
            strobe_rises++;
            if (strobe_rises == 2) second_rise_cyc = cyc;
         end
         if (mem_resp) begin
            resp_pulses++;
            if (resp_pulses == 1) first_resp_cyc = cyc;
            if (resp_pulses == 2) mem_read = 1'b0;
         end
         prev_read  = pmem_read;
         pmem_resp  = pmem_read;
         pmem_rdata = pmem_read ? 16'hC0DE : 16'h0000;
      end
      pmem_resp = 1'b0;
      checks++;
      if (strobe_rises != 2) begin
         failures++;
         $display("[TB] FAIL b2b_strobes got %0d expected 2", strobe_rises);
      end
      checks++;
      if (resp_pulses != 2) begin
         failures++;
         $display("[TB] FAIL b2b_resps got %0d expected 2", resp_pulses);
      end
      checks++;
      if (second_rise_cyc - first_resp_cyc != 2) begin
         failures++;
         $display("[TB] FAIL b2b_gap got %0d expected 2", second_rise_cyc - first_resp_cyc);
      end
      checks++;
      if (mem_rdata !== 16'hC0DE) begin
         failures++;
         $display("[TB] FAIL b2b_rdata got %h expected c0de", mem_rdata);
      end
   endtask

   // A stray pmem_resp while idle must not produce a CPU response.
   task automatic test_idle_resp();
      pmem_resp  = 1'b1;
      pmem_rdata = 16'h9999;
      repeat (2) @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = 16'h0000;
      checks++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || mem_rdata !== 16'hC0DE) begin
         failures++;
         $display("[TB] FAIL idle_resp got resp=%b r=%b rdata=%h expected 0 0 c0de",
                  mem_resp, pmem_read, mem_rdata);
      end
   endtask

   // Reset pulsed mid-ACCESS drops the transaction. A late pmem_resp must
   // then be ignored.
   task automatic test_reset_mid_access();
      mem_read    = 1'b1;
      mem_address = 16'h4444;
      @(negedge clk);
      checks++;
      if (pmem_read !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rst_mid_issue got %b expected 1", pmem_read);
      end
      rst_n    = 1'b0;
      mem_read = 1'b0;
      @(negedge clk);
      checks++;
      if (pmem_read !== 1'b0 || mem_resp !== 1'b0 || pmem_addr !== 16'h0000 || mem_rdata !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL rst_mid_clear got r=%b resp=%b addr=%h rdata=%h expected 0 0 0000 0000",
                  pmem_read, mem_resp, pmem_addr, mem_rdata);
      end
      rst_n      = 1'b1;
      pmem_resp  = 1'b1;
      pmem_rdata = 16'h1111;
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = 16'h0000;
      checks++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_mid_late_resp got resp=%b r=%b expected 0 0", mem_resp, pmem_read);
      end
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL rst_mid_after got resp=%b rdata=%h expected 0 0000", mem_resp, mem_rdata);
      end
   endtask

`ifdef MEM_TIMEOUT_EN
   // No memory response: the abort comes after four ACCESS cycles.
   task automatic test_timeout();
      mem_read    = 1'b1;
      mem_address = 16'h0010;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         checks++;
         if (pmem_read !== 1'b1 || mem_resp !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tmo_wait%0d got r=%b resp=%b expected 1 0", cyc, pmem_read, mem_resp);
         end
      end
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b1 || mem_err !== 1'b1 || mem_rdata !== 16'hDEAD || pmem_read !== 1'b0) begin
         failures++;
         $display("[TB] FAIL tmo_abort got resp=%b err=%b rdata=%h r=%b expected 1 1 dead 0",
                  mem_resp, mem_err, mem_rdata, pmem_read);
      end
      mem_read = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b0 || mem_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL tmo_after got resp=%b err=%b expected 0 0", mem_resp, mem_err);
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_read();
      test_write();
      test_simultaneous();
      test_back_to_back();
      test_idle_resp();
      test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
